// File: rtl/execute_mdu_if.sv
// execute_mdu_if: issue handshake, result bus and hazard/forwarding info of the iterative MDU
interface execute_mdu_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic              word;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] out_dst;
    logic              out_regwrite;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_wa;
    logic [XLEN-1:0]   fwd_result;
    logic              busy_valid;
    logic [REG_AW-1:0] busy_wa;
    modport master (
        output in_valid, op, word, a, b, dst, regwrite, out_ready,
        input  in_ready, out_valid, result, out_dst, out_regwrite,
               fwd_valid, fwd_wa, fwd_result, busy_valid, busy_wa
    );
    modport slave (
        input  in_valid, op, word, a, b, dst, regwrite, out_ready,
        output in_ready, out_valid, result, out_dst, out_regwrite,
               fwd_valid, fwd_wa, fwd_result, busy_valid, busy_wa
    );
endinterface

// File: rtl/execute_mdu.sv
// execute_mdu: 1-bit-per-cycle shift-add multiplier and restoring divider with result hold
module execute_mdu #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input logic         clk,
    input logic         resetn,
    input logic         flush,
    execute_mdu_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t              state, state_n;
    logic [XLEN-1:0]     x, y, rem, res;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       cnt;
    logic [2:0]          op_q;
    logic                w_q, neg_q, neg_r, rw_q;
    logic [REG_AW-1:0]   dst_q;
    logic                w, sgn, is_div, accept, dz, ovf, sc;
    logic [XLEN-1:0]     ae, be, am, bm, sc_res;
    logic [XLEN:0]       r_sh;
    logic                ge;
    logic [XLEN-1:0]     x_n, rem_n, quo, rmd, mhi, raw, fin;
    logic [2*XLEN-1:0]   acc_n, prod;

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        logic [63:0] t;
        t = {{32{v[31]}}, v};
        return t[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] zx(input logic [31:0] v);
        logic [63:0] t;
        t = {32'b0, v};
        return t[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] fitw(input logic wm, input logic [XLEN-1:0] v);
        return wm ? sx(v[31:0]) : v;
    endfunction

    assign w      = (XLEN == 64) && bus.word;
    assign is_div = bus.op inside {3'd3, 3'd4, 3'd5, 3'd6};
    assign sgn    = bus.op inside {3'd1, 3'd3, 3'd5};
    assign accept = bus.in_valid && bus.in_ready && !flush;
    assign ae     = w ? (sgn ? sx(bus.a[31:0]) : zx(bus.a[31:0])) : bus.a;
    assign be     = w ? (sgn ? sx(bus.b[31:0]) : zx(bus.b[31:0])) : bus.b;
    assign am     = (sgn && ae[XLEN-1]) ? -ae : ae;
    assign bm     = (sgn && be[XLEN-1]) ? -be : be;
    assign dz     = is_div && be == '0;
    assign ovf    = sgn && is_div && &be && ae == (w ? sx(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}});
    assign sc     = dz || ovf || bus.op == 3'd7;
    assign sc_res = fitw(w, bus.op == 3'd7 ? '0 :
                            dz ? (bus.op inside {3'd3, 3'd4} ? '1 : ae) :
                            bus.op == 3'd3 ? ae : '0);

    assign r_sh  = {rem, x[XLEN-1]};
    assign ge    = r_sh >= {1'b0, y};
    assign rem_n = ge ? r_sh[XLEN-1:0] - y : r_sh[XLEN-1:0];
    assign x_n   = {x[XLEN-2:0], ge};
    assign acc_n = {acc[2*XLEN-2:0], 1'b0} + (x[XLEN-1] ? {{XLEN{1'b0}}, y} : '0);
    assign prod  = neg_q ? -acc_n : acc_n;
    assign quo   = neg_q ? -x_n : x_n;
    assign rmd   = neg_r ? -rem_n : rem_n;
    assign mhi   = w_q ? XLEN'(prod[63:32]) : prod[2*XLEN-1:XLEN];
    assign raw   = op_q == 3'd0 ? prod[XLEN-1:0] :
                   op_q inside {3'd1, 3'd2} ? mhi :
                   op_q inside {3'd3, 3'd4} ? quo : rmd;
    assign fin   = fitw(w_q, raw);

    assign bus.in_ready     = state == IDLE;
    assign bus.out_valid    = state == DONE;
    assign bus.result       = res;
    assign bus.out_dst      = dst_q;
    assign bus.out_regwrite = rw_q;
    assign bus.fwd_valid    = bus.out_valid && rw_q;
    assign bus.fwd_wa       = dst_q;
    assign bus.fwd_result   = res;
    assign bus.busy_valid   = state == BUSY && rw_q;
    assign bus.busy_wa      = state == BUSY ? dst_q : '0;

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // next state: flush wins, shortcuts skip BUSY, DONE holds until accepted
    always_comb begin
        state_n = state;
        if (flush)                                 state_n = IDLE;
        else if (state == IDLE && accept)          state_n = sc ? DONE : BUSY;
        else if (state == BUSY && cnt == '0)       state_n = DONE;
        else if (state == DONE && bus.out_ready)   state_n = IDLE;
    end

    // operand capture at accept, one iteration per BUSY cycle, sign fix on the last one
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x     <= '0;
            y     <= '0;
            rem   <= '0;
            acc   <= '0;
            res   <= '0;
            cnt   <= '0;
            op_q  <= '0;
            w_q   <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            rw_q  <= 1'b0;
            dst_q <= '0;
        end else if (state == IDLE && accept) begin
            op_q  <= bus.op;
            w_q   <= w;
            rw_q  <= bus.regwrite;
            dst_q <= bus.dst;
            neg_q <= sgn && (ae[XLEN-1] ^ be[XLEN-1]);
            neg_r <= sgn && ae[XLEN-1];
            x     <= (is_div ? am : bm) << (w ? 6'd32 : 6'd0);
            y     <= is_div ? bm : am;
            rem   <= '0;
            acc   <= '0;
            cnt   <= w ? CW'(31) : CW'(XLEN - 1);
            if (sc) res <= sc_res;
        end else if (state == BUSY && !flush) begin
            x   <= x_n;
            rem <= rem_n;
            acc <= acc_n;
            cnt <= cnt == '0 ? '0 : cnt - 1'b1;
            if (cnt == '0) res <= fin;
        end
    end
endmodule

// File: tb/tb_execute_mdu.sv
// tb_execute_mdu: directed vectors with a result scoreboard for execute_mdu
module tb_execute_mdu;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [63:0] r;
        logic [4:0]  d;
        logic        rw;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        int          lat;
    } vec_t;
    vec_t vt[17];

    execute_mdu_if #(.XLEN(64), .REG_AW(5)) bus ();
    execute_mdu #(.XLEN(64), .REG_AW(5)) dut (.clk(clk), .resetn(resetn), .flush(flush), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: compare every transferred result against the oldest expectation
    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected result", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", bus.result, e.r);
                check("out_dst", 64'(bus.out_dst), 64'(e.d));
                check("out_regwrite", 64'(bus.out_regwrite), 64'(e.rw));
                check("fwd_valid", 64'(bus.fwd_valid), 64'(e.rw));
                check("fwd_wa", 64'(bus.fwd_wa), 64'(e.d));
                check("fwd_result", bus.fwd_result, e.r);
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic wd, input logic [63:0] av, input logic [63:0] bv,
                        input logic [4:0] d, input logic rw);
        for (int i = 0; i < 200 && !bus.in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check("in_ready wait", 64'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.word = wd;
        bus.a = av;
        bus.b = bv;
        bus.dst = d;
        bus.regwrite = rw;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_res(input logic [63:0] r, input logic [4:0] d, input logic rw, input int lat);
        int n;
        exp_q.push_back('{r, d, rw});
        n = 1;
        while (!bus.out_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'(lat));
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && bus.out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 64'(bus.out_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 65};
        vt[1]  = '{3'd1, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 65};
        vt[2]  = '{3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65};
        vt[3]  = '{3'd5, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65};
        vt[4]  = '{3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 65};
        vt[5]  = '{3'd6, 1'b0, 64'd100, 64'd7, 64'd2, 65};
        vt[6]  = '{3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1};
        vt[7]  = '{3'd3, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1};
        vt[8]  = '{3'd5, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1};
        vt[9]  = '{3'd3, 1'b1, 64'h0000000180000000, 64'd1, 64'hFFFFFFFF80000000, 33};
        vt[10] = '{3'd0, 1'b1, 64'h10000, 64'h10000, 64'd0, 33};
        vt[11] = '{3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'd1, 65};
        vt[12] = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        vt[13] = '{3'd7, 1'b0, 64'd123, 64'd45, 64'd0, 1};
        vt[14] = '{3'd1, 1'b1, 64'h00000000FFFFFFFE, 64'd3, 64'hFFFFFFFFFFFFFFFF, 33};
        vt[15] = '{3'd5, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 33};
        vt[16] = '{3'd4, 1'b1, 64'hFFFFFFFFFFFFFFFE, 64'd2, 64'h000000007FFFFFFF, 33};
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.word = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.dst = '0;
        bus.regwrite = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("reset in_ready", 64'(bus.in_ready), 1);
        check("reset out_valid", 64'(bus.out_valid), 0);
        check("reset fwd_valid", 64'(bus.fwd_valid), 0);
        check("reset busy_valid", 64'(bus.busy_valid), 0);
        check("reset result", bus.result, 0);
        check("reset out_dst", 64'(bus.out_dst), 0);
        check("reset busy_wa", 64'(bus.busy_wa), 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            send(vt[i].op, vt[i].w, vt[i].a, vt[i].b, 5'(i + 1), i[0]);
            expect_res(vt[i].r, 5'(i + 1), i[0], vt[i].lat);
            drain();
        end

        bus.out_ready = 1'b0;
        send(3'd4, 1'b0, 64'd100, 64'd7, 5'd21, 1'b1);
        expect_res(64'd14, 5'd21, 1'b1, 65);
        repeat (5) begin
            @(negedge clk);
            check("hold result", bus.result, 64'd14);
            check("hold out_dst", 64'(bus.out_dst), 64'd21);
            check("hold fwd_valid", 64'(bus.fwd_valid), 1);
            check("hold fwd_result", bus.fwd_result, 64'd14);
            check("hold in_ready", 64'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post hold in_ready", 64'(bus.in_ready), 1);
        check("post hold out_valid", 64'(bus.out_valid), 0);

        send(3'd0, 1'b0, 64'd3, 64'd5, 5'd9, 1'b1);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("busy_valid", 64'(bus.busy_valid), 1);
        check("busy_wa", 64'(bus.busy_wa), 64'd9);
        check("busy in_ready", 64'(bus.in_ready), 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush in_ready", 64'(bus.in_ready), 1);
        check("flush out_valid", 64'(bus.out_valid), 0);
        check("flush busy_valid", 64'(bus.busy_valid), 0);
        repeat (70) begin
            @(posedge clk);
            #1;
        end
        check("flushed op silent", 64'(bus.out_valid), 0);

        send(3'd3, 1'b0, 64'd50, 64'd5, 5'd12, 1'b1);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        check("areset in_ready", 64'(bus.in_ready), 1);
        check("areset out_valid", 64'(bus.out_valid), 0);
        check("areset busy_valid", 64'(bus.busy_valid), 0);
        check("areset fwd_result", bus.fwd_result, 0);
        check("areset out_dst", 64'(bus.out_dst), 0);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        send(3'd4, 1'b0, 64'd9, 64'd3, 5'd30, 1'b1);
        expect_res(64'd3, 5'd30, 1'b1, 65);
        drain();
        check("scoreboard empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_mdu.md
# execute_mdu

Iterative multiply/divide execute unit, the multi-cycle sibling of the single-cycle ALU execute stage. It accepts one operation at a time through a valid/ready handshake and computes it with 1-bit-per-cycle shift-add or restoring division. It holds the result until the pipeline accepts it. It exports forwarding and busy-destination information in the same form as the ALU path, so decode can stall dependents and bypass the result.

## Interface
Parameters:
- XLEN, 64, datapath width; 32 or 64.
- REG_AW, 5, destination register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of any in-flight or held operation.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 7 reserved.
- word  in  1  32-bit (W) variant; ignored when XLEN=32.
- a, b  in  XLEN  operands (dividend/divisor for DIV/REM).
- dst  in  REG_AW  destination register.
- regwrite  in  1  result is written back.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- result  out  XLEN  final result.
- out_dst  out  REG_AW  captured dst.
- out_regwrite  out  1  captured regwrite.
- fwd_valid  out  1  out_valid & out_regwrite.
- fwd_wa  out  REG_AW  = out_dst.
- fwd_result  out  XLEN  = result.
- busy_valid  out  1  in BUSY with captured regwrite=1.
- busy_wa  out  REG_AW  captured dst while BUSY.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE → BUSY on in_valid & in_ready & !flush. The operands, op, word, dst, and regwrite are latched at that edge.
- Shortcuts go IDLE → DONE directly, with the result computed at the accept edge:
  - divide by zero: DIV/DIVU give all ones; REM/REMU give the dividend.
  - signed overflow (most-negative ÷ −1): DIV gives the most-negative value; REM gives 0.
  - op 7: result 0.
- BUSY runs N iterations, where N = 32 if word, else XLEN. The counter counts N−1 down to 0. The transition BUSY → DONE happens on the edge that completes iteration 0.
- Signed ops (MULH, DIV, REM):
  - Operands are converted to magnitude at accept. The unsigned core iterates on magnitudes.
  - The sign correction is applied on the BUSY → DONE edge.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- MUL returns the low N bits of the product. MULH/MULHU return the high N bits.
- Word mode:
  - Operands are truncated to bits [31:0]. Signed ops sign-extend and unsigned ops zero-extend into the core.
  - The final result is the 32-bit result sign-extended to XLEN for all ops.
- DONE → IDLE on out_valid & out_ready.
- In DONE, result, out_dst, and out_regwrite are stable until the transfer completes.
- flush in any state → IDLE on that edge. out_valid falls and the operation is discarded. A flush in the same cycle as in_valid in IDLE blocks acceptance.
- Reset values:
  - state IDLE, so in_ready = 1 while resetn is low.
  - out_valid, busy_valid, fwd_valid = 0.
  - result, out_dst, busy_wa, counter = 0.

## Timing
- Accept at edge t. BUSY occupies cycles t+1 … t+N. out_valid is high from edge t+N+1. MUL at XLEN=64 therefore takes 65 cycles from accept to out_valid.
- Shortcut cases: out_valid is high from edge t+1.
- Minimum issue interval: a result transfer at edge u allows a new accept no earlier than edge u+1, because in_ready is low in DONE.
- in_ready, fwd_*, and busy_* are combinational from state and registers only, never from in_valid or out_ready.
- Reset assertion mid-BUSY or mid-DONE: outputs take their reset values immediately and asynchronously. There is no partial result.

## Test plan
- XLEN=64, MUL a=7, b=−3 → out_valid exactly 65 cycles after accept, result 0xFFFFFFFFFFFFFFEB. Same operands with MULH → 0xFFFFFFFFFFFFFFFF.
- DIV a=−7, b=2 → result −3. REM with the same operands → −1. DIVU a=100, b=7 → 14. REMU → 2.
- DIVU a=5, b=0 → out_valid 1 cycle after accept, result 0xFFFFFFFFFFFFFFFF. DIV 0x8000000000000000 / −1 → 0x8000000000000000, with REM → 0.
- word=1, DIV a=0x0000000180000000, b=1 → 0xFFFFFFFF80000000 after 33 cycles. MUL word=1, a=0x10000, b=0x10000 → 0.
- Hold out_ready low for 5 cycles in DONE → result, out_dst, and fwd_* remain constant and in_ready stays 0. After out_ready=1, the unit is in IDLE on the next cycle.
- Assert flush at BUSY cycle 10, then at a later point pulse resetn low mid-BUSY → each returns the unit to IDLE with out_valid=0. A new DIVU 9/3 issued afterwards returns 3.
